// File: rtl/step_pkg.sv
// step_pkg -- shared definitions for the step scheduler.
//   state_t   : FSM state encoding (IDLE, STEP, DWELL, DONE)
//   DWELL_DEF : default idle cycles between steps
//   CNT_W_DEF : default width of step-count fields
//   DWELL_W   : width of the dwell counter (covers DWELL up to 15)
//   pos_next  : next 2-bit stepper position for a given direction
package step_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_STEP  = 2'd1,
    ST_DWELL = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int DWELL_DEF = 4;
  localparam int CNT_W_DEF = 4;
  localparam int DWELL_W   = 4;

  // Position wraps naturally in 2 bits: 3->0 forward, 0->3 back.
  function automatic logic [1:0] pos_next(input logic [1:0] pos, input logic back);
    logic [1:0] nxt;
    if (back) begin
      nxt = pos - 2'd1;
    end else begin
      nxt = pos + 2'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2 -- two-way round-robin selector.
//   valid_a, valid_b : request presence
//   last_served      : requester served last (0 = A, 1 = B)
//   grant            : selected requester (0 = A, 1 = B)
// With no valid requester the output is the round-robin choice; callers
// gate it with the valids.
module rr_arb2 (
  input  logic valid_a,
  input  logic valid_b,
  input  logic last_served,
  output logic grant
);

  // Lone requester wins; on contention the one not served last wins.
  always_comb begin
    grant = 1'b0;
    if (valid_a && !valid_b) begin
      grant = 1'b0;
    end else if (!valid_a && valid_b) begin
      grant = 1'b1;
    end else begin
      grant = ~last_served;
    end
  end

endmodule

// File: rtl/step_scheduler.sv
// step_scheduler -- accepts step commands from two requesters and issues
// paced step pulses to a 4-position stepper.
//   iclk, irst                 : clock, async active-low reset
//   iReqA_*/oReqA_ready        : requester A command + handshake
//   iReqB_*/oReqB_ready        : requester B command + handshake
//   iAbort                     : terminate the active command
//   oStep                      : one-cycle step pulse
//   oBack                      : latched direction while a command is active
//   oPos                       : tracked stepper position
//   oBusy, oDone               : not-idle flag, one-cycle completion pulse
//   oGrant                     : owner of the current/last command (0 A, 1 B)
module step_scheduler
  import step_pkg::*;
#(
  parameter int DWELL = DWELL_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             iclk,
  input  logic             irst,
  input  logic             iReqA_valid,
  input  logic             iReqA_dir,
  input  logic [CNT_W-1:0] iReqA_cnt,
  output logic             oReqA_ready,
  input  logic             iReqB_valid,
  input  logic             iReqB_dir,
  input  logic [CNT_W-1:0] iReqB_cnt,
  output logic             oReqB_ready,
  input  logic             iAbort,
  output logic             oStep,
  output logic             oBack,
  output logic [1:0]       oPos,
  output logic             oBusy,
  output logic             oDone,
  output logic             oGrant
);

  localparam logic [DWELL_W-1:0] DWELL_LOAD = DWELL_W'(DWELL - 1);

  state_t             state_r;
  state_t             state_nxt_s;
  logic [CNT_W-1:0]   rem_r;
  logic [DWELL_W-1:0] dwell_r;
  logic [1:0]         pos_r;
  logic               step_r;
  logic               back_r;
  logic               busy_r;
  logic               done_r;
  logic               grant_r;
  logic               last_r;

  logic               grant_s;
  logic               ready_a_s;
  logic               ready_b_s;
  logic               hs_s;
  logic               sel_dir_s;
  logic [CNT_W-1:0]   sel_cnt_s;
  logic               dir_eff_s;

  rr_arb2 u_arb (
    .valid_a     (iReqA_valid),
    .valid_b     (iReqB_valid),
    .last_served (last_r),
    .grant       (grant_s)
  );

  // Handshake qualification; readies are held low while reset is asserted.
  always_comb begin
    ready_a_s = 1'b0;
    ready_b_s = 1'b0;
    if (irst && (state_r == ST_IDLE)) begin
      ready_a_s = iReqA_valid && !grant_s;
      ready_b_s = iReqB_valid && grant_s;
    end else begin
      ready_a_s = 1'b0;
      ready_b_s = 1'b0;
    end
    hs_s      = ready_a_s || ready_b_s;
    sel_dir_s = grant_s ? iReqB_dir : iReqA_dir;
    sel_cnt_s = grant_s ? iReqB_cnt : iReqA_cnt;
    // The first step uses the direction being accepted this cycle.
    dir_eff_s = (state_r == ST_IDLE) ? sel_dir_s : back_r;
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (hs_s) begin
          state_nxt_s = (sel_cnt_s != '0) ? ST_STEP : ST_DONE;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_STEP: begin
        if (iAbort) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_DWELL;
        end
      end
      ST_DWELL: begin
        if (iAbort) begin
          state_nxt_s = ST_DONE;
        end else if (dwell_r == '0) begin
          state_nxt_s = (rem_r == '0) ? ST_DONE : ST_STEP;
        end else begin
          state_nxt_s = ST_DWELL;
        end
      end
      ST_DONE: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State, counters and registered outputs; outputs are derived from the
  // next state so they line up with the state they describe.
  always_ff @(posedge iclk or negedge irst) begin
    if (!irst) begin
      state_r <= ST_IDLE;
      rem_r   <= '0;
      dwell_r <= '0;
      pos_r   <= 2'd0;
      step_r  <= 1'b0;
      back_r  <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      grant_r <= 1'b0;
      last_r  <= 1'b1;
    end else begin
      state_r <= state_nxt_s;
      step_r  <= (state_nxt_s == ST_STEP);
      busy_r  <= (state_nxt_s != ST_IDLE);
      done_r  <= (state_nxt_s == ST_DONE);
      if (state_nxt_s == ST_STEP) begin
        pos_r <= pos_next(pos_r, dir_eff_s);
      end
      case (state_r)
        ST_IDLE: begin
          if (hs_s) begin
            grant_r <= grant_s;
            back_r  <= sel_dir_s;
            rem_r   <= sel_cnt_s;
          end
        end
        ST_STEP: begin
          if (rem_r != '0) begin
            rem_r <= rem_r - CNT_W'(1);
          end
          dwell_r <= DWELL_LOAD;
        end
        ST_DWELL: begin
          if (dwell_r != '0) begin
            dwell_r <= dwell_r - DWELL_W'(1);
          end
        end
        ST_DONE: begin
          last_r  <= grant_r;
          back_r  <= 1'b0;
          rem_r   <= '0;
          dwell_r <= '0;
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  assign oReqA_ready = ready_a_s;
  assign oReqB_ready = ready_b_s;
  assign oStep       = step_r;
  assign oBack       = back_r;
  assign oPos        = pos_r;
  assign oBusy       = busy_r;
  assign oDone       = done_r;
  assign oGrant      = grant_r;

endmodule

// File: tb/tb_step_scheduler.sv
// tb_step_scheduler -- directed self-checking bench for step_scheduler
// (DWELL=4, CNT_W=4). Outputs are sampled 1 time unit after the rising edge.
module tb_step_scheduler;

  logic       iclk = 1'b0;
  logic       irst = 1'b0;
  logic       iReqA_valid = 1'b0;
  logic       iReqA_dir = 1'b0;
  logic [3:0] iReqA_cnt = 4'd0;
  logic       oReqA_ready;
  logic       iReqB_valid = 1'b0;
  logic       iReqB_dir = 1'b0;
  logic [3:0] iReqB_cnt = 4'd0;
  logic       oReqB_ready;
  logic       iAbort = 1'b0;
  logic       oStep;
  logic       oBack;
  logic [1:0] oPos;
  logic       oBusy;
  logic       oDone;
  logic       oGrant;

  int checks = 0;
  int failures = 0;

  step_scheduler #(.DWELL(4), .CNT_W(4)) dut (
    .iclk        (iclk),
    .irst        (irst),
    .iReqA_valid (iReqA_valid),
    .iReqA_dir   (iReqA_dir),
    .iReqA_cnt   (iReqA_cnt),
    .oReqA_ready (oReqA_ready),
    .iReqB_valid (iReqB_valid),
    .iReqB_dir   (iReqB_dir),
    .iReqB_cnt   (iReqB_cnt),
    .oReqB_ready (oReqB_ready),
    .iAbort      (iAbort),
    .oStep       (oStep),
    .oBack       (oBack),
    .oPos        (oPos),
    .oBusy       (oBusy),
    .oDone       (oDone),
    .oGrant      (oGrant)
  );

  always #5 iclk = ~iclk;

  task automatic tick();
    @(posedge iclk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance until oDone is seen, bounded by a cycle budget.
  task automatic wait_done(input int budget, input string tag);
    int n;
    n = 0;
    while (oDone !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    check(tag, {7'd0, oDone}, 8'd1);
  endtask

  initial begin
    // ---- reset state, with A already requesting ----
    iReqA_valid = 1'b1; iReqA_dir = 1'b0; iReqA_cnt = 4'd3;
    tick(); tick();
    check("rst_readyA", {7'd0, oReqA_ready}, 8'd0);
    check("rst_step",   {7'd0, oStep},  8'd0);
    check("rst_pos",    {6'd0, oPos},   8'd0);
    check("rst_busy",   {7'd0, oBusy},  8'd0);
    check("rst_done",   {7'd0, oDone},  8'd0);
    check("rst_grant",  {7'd0, oGrant}, 8'd0);
    check("rst_back",   {7'd0, oBack},  8'd0);

    // ---- A fwd cnt=3: steps at t+1,t+6,t+11, done at t+16 ----
    irst = 1'b1;
    #1;
    check("a_readyA", {7'd0, oReqA_ready}, 8'd1);
    check("a_readyB", {7'd0, oReqB_ready}, 8'd0);
    tick();                                   // handshake edge (cycle t)
    iReqA_valid = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      check("a_step", {7'd0, oStep}, ((c - 1) % 5 == 0 && c <= 11) ? 8'd1 : 8'd0);
      check("a_done", {7'd0, oDone}, (c == 16) ? 8'd1 : 8'd0);
      check("a_busy", {7'd0, oBusy}, 8'd1);
      if ((c - 1) % 5 == 0 && c <= 11) check("a_pos", {6'd0, oPos}, 8'((c + 4) / 5));
      if (c < 16) tick();
    end
    check("a_readyA_busy", {7'd0, oReqA_ready}, 8'd0);
    tick();
    check("a_idle_busy", {7'd0, oBusy}, 8'd0);
    check("a_idle_pos",  {6'd0, oPos},  8'd3);

    // ---- A fwd cnt=1: wrap 3 -> 0 ----
    iReqA_valid = 1'b1; iReqA_cnt = 4'd1;
    tick();
    iReqA_valid = 1'b0;
    check("wrap_pos", {6'd0, oPos}, 8'd0);
    wait_done(20, "wrap_done");
    tick();

    // ---- B back cnt=2 from 0: pos 3 then 2, oBack high throughout ----
    iReqB_valid = 1'b1; iReqB_dir = 1'b1; iReqB_cnt = 4'd2;
    #1;
    check("b_readyB", {7'd0, oReqB_ready}, 8'd1);
    check("b_readyA", {7'd0, oReqA_ready}, 8'd0);
    tick();
    iReqB_valid = 1'b0;
    check("b_step1", {7'd0, oStep},  8'd1);
    check("b_pos1",  {6'd0, oPos},   8'd3);
    check("b_grant", {7'd0, oGrant}, 8'd1);
    for (int c = 2; c <= 11; c++) begin
      tick();
      check("b_back", {7'd0, oBack}, 8'd1);
      if (c == 6) check("b_step2", {7'd0, oStep}, 8'd1);
      if (c == 6) check("b_pos2",  {6'd0, oPos},  8'd2);
    end
    check("b_done", {7'd0, oDone}, 8'd1);
    tick();
    check("b_back_idle", {7'd0, oBack}, 8'd0);

    // ---- round robin with cnt=0, no accept in DONE ----
    iReqA_valid = 1'b1; iReqA_dir = 1'b0; iReqA_cnt = 4'd0;
    iReqB_valid = 1'b1; iReqB_dir = 1'b0; iReqB_cnt = 4'd0;
    #1;
    check("rr1_readyA", {7'd0, oReqA_ready}, 8'd1);
    check("rr1_readyB", {7'd0, oReqB_ready}, 8'd0);
    tick();
    check("z_done",     {7'd0, oDone},  8'd1);
    check("z_step",     {7'd0, oStep},  8'd0);
    check("z_grant",    {7'd0, oGrant}, 8'd0);
    check("z_pos",      {6'd0, oPos},   8'd2);
    check("z_noreadyA", {7'd0, oReqA_ready}, 8'd0);
    check("z_noreadyB", {7'd0, oReqB_ready}, 8'd0);
    tick();
    check("rr2_readyB", {7'd0, oReqB_ready}, 8'd1);
    check("rr2_readyA", {7'd0, oReqA_ready}, 8'd0);
    tick();
    check("rr2_grant", {7'd0, oGrant}, 8'd1);
    check("rr2_done",  {7'd0, oDone},  8'd1);
    tick();
    check("rr3_readyA", {7'd0, oReqA_ready}, 8'd1);
    tick();
    iReqA_valid = 1'b0; iReqB_valid = 1'b0;
    check("rr3_grant", {7'd0, oGrant}, 8'd0);
    tick();
    check("rr_idle", {7'd0, oBusy}, 8'd0);

    // ---- abort in the DWELL after the first of 5 steps ----
    iReqA_valid = 1'b1; iReqA_dir = 1'b0; iReqA_cnt = 4'd5;
    tick();
    iReqA_valid = 1'b0;
    check("ab_pos1", {6'd0, oPos}, 8'd3);
    tick();
    iAbort = 1'b1;
    tick();
    iAbort = 1'b0;
    check("ab_done", {7'd0, oDone}, 8'd1);
    check("ab_step", {7'd0, oStep}, 8'd0);
    check("ab_pos",  {6'd0, oPos},  8'd3);
    tick();
    check("ab_idle", {7'd0, oBusy}, 8'd0);
    check("ab_pos_idle", {6'd0, oPos}, 8'd3);

    // ---- async reset during DWELL, then immediate acceptance ----
    iReqB_valid = 1'b1; iReqB_dir = 1'b1; iReqB_cnt = 4'd3;
    tick();
    iReqB_valid = 1'b0;
    check("rs_pos",   {6'd0, oPos},   8'd2);
    check("rs_grant", {7'd0, oGrant}, 8'd1);
    tick();
    #2;
    irst = 1'b0;
    #1;
    check("rs_step",  {7'd0, oStep},  8'd0);
    check("rs_pos0",  {6'd0, oPos},   8'd0);
    check("rs_busy",  {7'd0, oBusy},  8'd0);
    check("rs_done",  {7'd0, oDone},  8'd0);
    check("rs_grant0",{7'd0, oGrant}, 8'd0);
    check("rs_back",  {7'd0, oBack},  8'd0);
    tick();
    iReqA_valid = 1'b1; iReqA_dir = 1'b0; iReqA_cnt = 4'd1;
    iReqB_valid = 1'b1; iReqB_dir = 1'b0; iReqB_cnt = 4'd1;
    irst = 1'b1;
    #1;
    check("rs_readyA", {7'd0, oReqA_ready}, 8'd1);
    check("rs_readyB", {7'd0, oReqB_ready}, 8'd0);
    tick();
    iReqA_valid = 1'b0; iReqB_valid = 1'b0;
    check("rs_step1", {7'd0, oStep},  8'd1);
    check("rs_pos1",  {6'd0, oPos},   8'd1);
    check("rs_grantA",{7'd0, oGrant}, 8'd0);
    wait_done(20, "rs_final_done");
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
